rom_download_writer: RTL



---
 rtl/rom_loader_pkg.sv | 32 +++
 rtl/rom_download_writer_word_fifo.sv | 71 +++++++
 rtl/rom_download_writer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download write path.
// Defines the session states, the FIFO entry layout and a lane-masking helper.
package rom_loader_pkg;

    localparam int unsigned SDRAM_ADDR_WIDTH = 23;
    localparam int unsigned BYTE_LANES       = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [SDRAM_ADDR_WIDTH-1:0] addr;
        logic [31:0]                 data;
    } fifo_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(fifo_entry_t);

    // Lanes that never received a byte must read back as 0x00.
    function automatic logic [31:0] mask_lanes(input logic [31:0]           data,
                                               input logic [BYTE_LANES-1:0] valid);
        logic [31:0] masked;
        masked = '0;
        for (int i = 0; i < BYTE_LANES; i++) begin
            masked[8*i +: 8] = data[8*i +: 8] & {8{valid[i]}};
        end
        return masked;
    endfunction

endpackage

// File: rtl/rom_download_writer_word_fifo.sv
// Synchronous FIFO of {address, data} entries with full/empty flags and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module word_fifo
    import rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [ENTRY_WIDTH-1:0]     push_entry,
    input  logic                       pop,
    output logic [ENTRY_WIDTH-1:0]     head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/rom_download_writer.sv
// ioctl download to SDRAM write path: packs bytes into 32-bit little-endian words,
// buffers them and issues req/ack writes, reporting busy/done/overflow.
module rom_download_writer
    import rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  ioctl_wr,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [31:0]           sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                        state_q, state_d;
    logic                          dl_q;
    logic [31:0]                   asm_data_q, asm_data_d;
    logic [BYTE_LANES-1:0]         asm_valid_q, asm_valid_d;
    logic [SDRAM_ADDR_WIDTH-1:0]   asm_addr_q, asm_addr_d;
    logic                          req_q, req_d;
    logic                          overflow_q, overflow_d;

    logic                          dl_rise, dl_fall;
    logic                          wr_accept;
    logic [SDRAM_ADDR_WIDTH-1:0]   wr_addr;
    logic [1:0]                    lane;
    logic [BYTE_LANES-1:0]         lane_sel;
    logic [31:0]                   merged_data;
    logic                          any_valid;

    logic                          push, pop;
    fifo_entry_t                   push_entry;
    logic [ENTRY_WIDTH-1:0]        fifo_head;
    fifo_entry_t                   head_entry;
    logic                          fifo_empty, fifo_full;
    logic [CNT_W-1:0]              fifo_count;

    assign dl_rise   = ioctl_download && !dl_q;
    assign dl_fall   = !ioctl_download && dl_q;
    assign wr_accept = ioctl_wr && ioctl_download && (state_q == LOAD);
    assign wr_addr   = ioctl_addr[24:2];
    assign lane      = ioctl_addr[1:0];
    assign lane_sel  = BYTE_LANES'(1) << lane;
    assign any_valid = |asm_valid_q;
    assign pop       = req_q && sdram_ack;

    always_comb begin
        merged_data = asm_data_q;
        merged_data[{lane, 3'b000} +: 8] = ioctl_data;
    end

    // Byte packing and push generation; at most one push per cycle.
    always_comb begin
        asm_data_d  = asm_data_q;
        asm_valid_d = asm_valid_q;
        asm_addr_d  = asm_addr_q;
        push        = 1'b0;
        push_entry  = '0;
        if (state_q == LOAD && dl_fall) begin
            if (any_valid) begin
                push            = 1'b1;
                push_entry.addr = asm_addr_q;
                push_entry.data = mask_lanes(asm_data_q, asm_valid_q);
                asm_valid_d     = '0;
            end
        end else if (wr_accept) begin
            if (any_valid && (wr_addr != asm_addr_q)) begin
                // Flush the partial word; the new byte starts a fresh one.
                push            = 1'b1;
                push_entry.addr = asm_addr_q;
                push_entry.data = mask_lanes(asm_data_q, asm_valid_q);
                asm_data_d      = merged_data;
                asm_valid_d     = lane_sel;
                asm_addr_d      = wr_addr;
            end else if (lane == 2'd3) begin
                push            = 1'b1;
                push_entry.addr = wr_addr;
                push_entry.data = mask_lanes(merged_data, asm_valid_q | lane_sel);
                asm_valid_d     = '0;
                asm_addr_d      = wr_addr;
            end else begin
                asm_data_d  = merged_data;
                asm_valid_d = asm_valid_q | lane_sel;
                asm_addr_d  = wr_addr;
            end
        end
    end

    word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_word_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    assign head_entry = fifo_head;

    // req follows the FIFO one cycle late; it stays up across an ack if more remain.
    always_comb begin
        req_d      = !fifo_empty && !(pop && (fifo_count == CNT_W'(1)));
        overflow_d = overflow_q;
        if (dl_rise) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dl_rise) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (dl_fall) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dl_rise) begin
                    state_d = LOAD;
                end else if (fifo_empty && !req_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            asm_data_q  <= '0;
            asm_valid_q <= '0;
            asm_addr_q  <= '0;
            req_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            asm_data_q  <= asm_data_d;
            asm_valid_q <= asm_valid_d;
            asm_addr_q  <= asm_addr_d;
            req_q       <= req_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_we   = req_q;
    assign sdram_addr = req_q ? head_entry.addr[ADDR_WIDTH-1:0] : '0;
    assign sdram_data = req_q ? head_entry.data : '0;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE) || !fifo_empty || any_valid;

endmodule
